fnd_scan_decoder: RTL and testbench
===================================

Name: fnd_scan_decoder

Overview:
- Receive-side counterpart of the watch's FND display driver.
- Samples the three multiplexed 7-segment buses (hour/min/sec) and their per-digit select lines, then decodes the segment patterns back into binary hour/minute/second.
- Used as an on-chip display readback/checker: it confirms that what is driven to the FNDs matches the clock core, and it flags corrupt, blank or stale display data.

Parameters:
SEG_ACTIVE_LOW, 0, 1 = segment lit when bit is 0; patterns are inverted before decode
SEL_ACTIVE_LOW, 0, 1 = digit select asserted when line is 0
STABLE_CYCLES, 4, consecutive identical clk cycles (sel + seg) required before a digit is captured; legal range 1..255
TIMEOUT_CYCLES, 65535, clk cycles with no good frame before time_valid drops; legal range 1..2^20-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
hourFNDsel2  in  1  hour tens-digit select
hourFNDsel1  in  1  hour ones-digit select
minFNDsel2  in  1  minute tens-digit select
minFNDsel1  in  1  minute ones-digit select
secFNDsel2  in  1  second tens-digit select
secFNDsel1  in  1  second ones-digit select
hourFND  in  7  hour segment bus, bit order {g,f,e,d,c,b,a}
minFND  in  7  minute segment bus, same order
secFND  in  7  second segment bus, same order
hour_out  out  5  decoded hour, binary 0..23
min_out  out  6  decoded minute, binary 0..59
sec_out  out  6  decoded second, binary 0..59
time_valid  out  1  level; a good frame has been decoded within TIMEOUT_CYCLES
frame_done  out  1  one-cycle pulse when the outputs update
blank_frame  out  1  one-cycle pulse when a frame is discarded because it contains a blank digit
seg_error  out  1  one-cycle pulse when a frame has an illegal pattern or an out-of-range value
error_count  out  8  saturating count of seg_error pulses

Behaviour:
- Reset (reset low, async): all outputs 0, all counters 0, all slots empty. The block resumes capture on the first clk edge after reset deasserts. Reset mid-frame discards the partial frame.
- Capture channels: three identical units (hour, min, sec), each with two slots (tens, ones).
- Per channel, on each clk:
  - Exactly one select asserted: the active slot and the bus value are compared against the previous cycle. If identical, stable_cnt increments (saturates at STABLE_CYCLES); otherwise stable_cnt = 1.
  - Both selects asserted, or neither: idle; stable_cnt = 0 and no capture.
  - When stable_cnt reaches STABLE_CYCLES, the digit is decoded and written to the slot once per dwell. The slot's fresh bit is set, and the slot is not rewritten until the select or pattern changes.
  - A slot recaptured before the frame completes is overwritten; the latest value wins.
- Decode (after polarity correction), gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 0000000 decodes to BLANK; any other pattern decodes to INVALID.
- Frame evaluation:
  - Triggered in the cycle after all six fresh bits are set; all fresh bits clear in that same evaluation cycle.
  - A capture landing in the evaluation cycle sets its fresh bit for the next frame and is not lost.
- Evaluation priority:
  1. Any INVALID digit: seg_error pulse, error_count+1 (saturates at 255), outputs hold.
  2. Otherwise any BLANK digit (blink in setting mode): blank_frame pulse, outputs hold, no error.
  3. Otherwise a range check: hour = 10*tens + ones must be <= 23; min and sec tens must be <= 5. A failure raises seg_error as in step 1.
  4. Otherwise hour_out/min_out/sec_out update, frame_done pulses and time_valid = 1, all in the same cycle.
- Latency: outputs update 2 clk cycles after the sixth digit's capture edge.
- Timeout:
  - The timeout counter clears on frame_done and otherwise increments.
  - On reaching TIMEOUT_CYCLES, time_valid = 0 and the counter holds until the next good frame.
  - hour/min/sec keep their last values.
- frame_done, seg_error and blank_frame are mutually exclusive. They are registered, one cycle wide, and never back-to-back from the same frame.

Test Plan:
- Release reset, drive 12:34:56 correctly multiplexed with 8-cycle dwell per digit -> after the sixth capture plus 2 cycles, hour_out=12, min_out=34, sec_out=56; frame_done single pulse; time_valid=1.
- Sec ones bus = 1111110 (non-digit) during a 23:59:59 frame -> seg_error pulse, error_count=1, outputs keep the prior frame's value; 300 consecutive bad frames -> error_count saturates at 255.
- Hour tens pattern blank (0000000) for one frame, then a normal frame -> blank_frame pulse, error_count unchanged; the next frame gives frame_done.
- Hour digits decode to 2 and 7 (27:00:00) -> seg_error; outputs unchanged; time_valid stays 1.
- Dwell of STABLE_CYCLES-1 cycles on every digit -> no captures, no pulses; after TIMEOUT_CYCLES, time_valid falls to 0.
- Assert reset for 1 cycle after 5 of 6 digits are captured -> all outputs 0; one full new frame is required before frame_done; SEG_ACTIVE_LOW=1 run with inverted patterns yields identical results.

Source files
------------

// File: rtl/fnd_scan_decoder.sv
// -----------------------------------------------------------------------------
// fnd_scan_decoder
//
// Receive-side readback of the watch's multiplexed FND display. Each of the
// three channels (hour, min, sec) watches its segment bus and its two digit
// selects. A digit is captured once it has been held steady for STABLE_CYCLES
// clocks. When all six slots hold a fresh capture, the frame is checked and
// either published as binary time or flagged as blank or corrupt.
//
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   {hour,min,sec}FNDsel2/sel1   tens/ones digit selects per channel
//   hourFND, minFND, secFND      segment buses, bit order {g,f,e,d,c,b,a}
//   hour_out/min_out/sec_out     last good decoded time
//   time_valid                   a good frame was seen within TIMEOUT_CYCLES
//   frame_done                   1-cycle pulse: outputs updated
//   blank_frame                  1-cycle pulse: frame dropped, blank digit
//   seg_error                    1-cycle pulse: illegal pattern or range
//   error_count                  saturating count of seg_error pulses
// -----------------------------------------------------------------------------
module fnd_scan_decoder #(
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit SEL_ACTIVE_LOW = 1'b0,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hourFNDsel2,
   input  logic       hourFNDsel1,
   input  logic       minFNDsel2,
   input  logic       minFNDsel1,
   input  logic       secFNDsel2,
   input  logic       secFNDsel1,
   input  logic [6:0] hourFND,
   input  logic [6:0] minFND,
   input  logic [6:0] secFND,
   output logic [4:0] hour_out,
   output logic [5:0] min_out,
   output logic [5:0] sec_out,
   output logic       time_valid,
   output logic       frame_done,
   output logic       blank_frame,
   output logic       seg_error,
   output logic [7:0] error_count
);

   localparam logic [3:0]  CODE_BLANK   = 4'd10;
   localparam logic [3:0]  CODE_INVALID = 4'd11;
   localparam logic [7:0]  STABLE_MAX   = 8'(STABLE_CYCLES);
   localparam logic [19:0] TIMEOUT_MAX  = 20'(TIMEOUT_CYCLES);
   localparam int CH_HOUR   = 0;
   localparam int CH_MIN    = 1;
   localparam int CH_SEC    = 2;
   localparam int SLOT_ONES = 0;
   localparam int SLOT_TENS = 1;

   // Segment pattern (active-high, gfedcba) to digit code; 10 = blank, 11 = invalid.
   function automatic logic [3:0] decode_seg(input logic [6:0] seg);
      logic [3:0] code;
      case (seg)
         7'b0111111: code = 4'd0;
         7'b0000110: code = 4'd1;
         7'b1011011: code = 4'd2;
         7'b1001111: code = 4'd3;
         7'b1100110: code = 4'd4;
         7'b1101101: code = 4'd5;
         7'b1111101: code = 4'd6;
         7'b0000111: code = 4'd7;
         7'b1111111: code = 4'd8;
         7'b1101111: code = 4'd9;
         7'b0000000: code = CODE_BLANK;
         default:    code = CODE_INVALID;
      endcase
      return code;
   endfunction

   // Polarity-corrected channel inputs
   logic       sel_tens [3];
   logic       sel_ones [3];
   logic [6:0] seg_bus  [3];

   // Per-channel stability tracking
   logic       active      [3];
   logic       same        [3];
   logic [7:0] cnt_next    [3];
   logic [5:0] cap_mask;             // bit 2*channel + slot
   logic       prev_active [3];
   logic       prev_slot   [3];
   logic [6:0] prev_seg    [3];
   logic [7:0] stable_cnt  [3];

   // Slots, frame snapshot and evaluation
   logic [3:0]  slot_code [3][2];
   logic [3:0]  snap_code [3][2];
   logic [5:0]  fresh;
   logic        eval_pend;
   logic        any_invalid, any_blank, range_bad;
   logic        frame_bad, frame_ok;
   logic [4:0]  hour_val;
   logic [5:0]  min_val, sec_val;
   logic [19:0] timeout_cnt;

   always_comb begin
      sel_tens[CH_HOUR] = hourFNDsel2 ^ SEL_ACTIVE_LOW;
      sel_ones[CH_HOUR] = hourFNDsel1 ^ SEL_ACTIVE_LOW;
      sel_tens[CH_MIN]  = minFNDsel2  ^ SEL_ACTIVE_LOW;
      sel_ones[CH_MIN]  = minFNDsel1  ^ SEL_ACTIVE_LOW;
      sel_tens[CH_SEC]  = secFNDsel2  ^ SEL_ACTIVE_LOW;
      sel_ones[CH_SEC]  = secFNDsel1  ^ SEL_ACTIVE_LOW;
      seg_bus[CH_HOUR]  = hourFND ^ {7{SEG_ACTIVE_LOW}};
      seg_bus[CH_MIN]   = minFND  ^ {7{SEG_ACTIVE_LOW}};
      seg_bus[CH_SEC]   = secFND  ^ {7{SEG_ACTIVE_LOW}};
   end

   always_comb begin
      // NOTE: outputs of a combinational block get a default before any branch, so no path can infer a latch.
      cap_mask = '0;
      for (int c = 0; c < 3; c++) begin
         active[c] = sel_tens[c] ^ sel_ones[c];
         same[c]   = prev_active[c] && (prev_slot[c] == sel_tens[c]) &&
                     (prev_seg[c] == seg_bus[c]);
         if (!active[c])                        cnt_next[c] = '0;
         else if (!same[c])                     cnt_next[c] = 8'd1;
         else if (stable_cnt[c] == STABLE_MAX)  cnt_next[c] = STABLE_MAX;
         else                                   cnt_next[c] = stable_cnt[c] + 8'd1;
         // Capture only when the count first reaches the threshold: one write per dwell.
         if (active[c] && (cnt_next[c] == STABLE_MAX) &&
             !(same[c] && (stable_cnt[c] == STABLE_MAX)))
            cap_mask[2*c + int'(sel_tens[c])] = 1'b1;
      end
   end

   always_comb begin
      any_invalid = 1'b0;
      any_blank   = 1'b0;
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < 2; s++) begin
            if (snap_code[c][s] == CODE_INVALID) any_invalid = 1'b1;
            if (snap_code[c][s] == CODE_BLANK)   any_blank   = 1'b1;
         end
      end
      // Only meaningful once every digit is known to be 0..9.
      range_bad = (snap_code[CH_HOUR][SLOT_TENS] > 4'd2) ||
                  ((snap_code[CH_HOUR][SLOT_TENS] == 4'd2) &&
                   (snap_code[CH_HOUR][SLOT_ONES] > 4'd3)) ||
                  (snap_code[CH_MIN][SLOT_TENS] > 4'd5) ||
                  (snap_code[CH_SEC][SLOT_TENS] > 4'd5);
      frame_bad = eval_pend && (any_invalid || (!any_blank && range_bad));
      frame_ok  = eval_pend && !any_invalid && !any_blank && !range_bad;
      hour_val  = {1'b0, snap_code[CH_HOUR][SLOT_TENS]} * 5'd10 + {1'b0, snap_code[CH_HOUR][SLOT_ONES]};
      min_val   = {2'b0, snap_code[CH_MIN][SLOT_TENS]}  * 6'd10 + {2'b0, snap_code[CH_MIN][SLOT_ONES]};
      sec_val   = {2'b0, snap_code[CH_SEC][SLOT_TENS]}  * 6'd10 + {2'b0, snap_code[CH_SEC][SLOT_ONES]};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the slot and snapshot arrays are a handful of registers and are cleared too, so a reset mid-frame leaves no stale digits.
         for (int c = 0; c < 3; c++) begin
            prev_active[c] <= 1'b0;
            prev_slot[c]   <= 1'b0;
            prev_seg[c]    <= '0;
            stable_cnt[c]  <= '0;
            for (int s = 0; s < 2; s++) begin
               slot_code[c][s] <= '0;
               snap_code[c][s] <= '0;
            end
         end
         fresh       <= '0;
         eval_pend   <= 1'b0;
         timeout_cnt <= '0;
         hour_out    <= '0;
         min_out     <= '0;
         sec_out     <= '0;
         time_valid  <= 1'b0;
         frame_done  <= 1'b0;
         blank_frame <= 1'b0;
         seg_error   <= 1'b0;
         error_count <= '0;
      end else begin
         frame_done  <= 1'b0;
         blank_frame <= 1'b0;
         seg_error   <= 1'b0;

         for (int c = 0; c < 3; c++) begin
            prev_active[c] <= active[c];
            prev_slot[c]   <= sel_tens[c];
            prev_seg[c]    <= seg_bus[c];
            stable_cnt[c]  <= cnt_next[c];
            for (int s = 0; s < 2; s++)
               if (cap_mask[2*c + s]) slot_code[c][s] <= decode_seg(seg_bus[c]);
         end

         // A capture landing in the evaluation cycle becomes fresh for the next frame.
         if (&fresh) begin
            fresh     <= cap_mask;
            eval_pend <= 1'b1;
            for (int c = 0; c < 3; c++)
               for (int s = 0; s < 2; s++)
                  snap_code[c][s] <= slot_code[c][s];
         end else begin
            fresh     <= fresh | cap_mask;
            eval_pend <= 1'b0;
         end

         if (frame_bad) begin
            seg_error <= 1'b1;
            if (error_count != 8'hFF) error_count <= error_count + 8'd1;
         end else if (eval_pend && any_blank) begin
            blank_frame <= 1'b1;
         end

         if (frame_ok) begin
            hour_out    <= hour_val;
            min_out     <= min_val;
            sec_out     <= sec_val;
            frame_done  <= 1'b1;
            time_valid  <= 1'b1;
            timeout_cnt <= '0;
         end else if (timeout_cnt != TIMEOUT_MAX) begin
            timeout_cnt <= timeout_cnt + 20'd1;
            if (timeout_cnt + 20'd1 == TIMEOUT_MAX) time_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_decoder
//
// Two instances: dut_hi with active-high segments/selects and dut_lo with
// active-low segments/selects driven by the inverted buses. Both are held to
// one reference model that classifies each frame from the digit table and the
// hour/minute/second range rules, and predicts time_valid from the cycle of
// the last good frame.
// -----------------------------------------------------------------------------
module tb_fnd_scan_decoder;

   localparam int S  = 4;    // STABLE_CYCLES
   localparam int TO = 200;  // TIMEOUT_CYCLES
   localparam int DW = 8;    // normal dwell per digit

   typedef enum int {K_NONE, K_DONE, K_BLANK, K_ERR} kind_e;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       h2, h1, m2, m1, s2, s1;
   logic [6:0] hseg, mseg, sseg;

   logic [4:0] hour_o [2];
   logic [5:0] min_o  [2];
   logic [5:0] sec_o  [2];
   logic       valid  [2];
   logic       done   [2];
   logic       blank  [2];
   logic       serr   [2];
   logic [7:0] ecnt   [2];

   fnd_scan_decoder #(.SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0),
                      .STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut_hi (
      .clk(clk), .reset(reset),
      .hourFNDsel2(h2), .hourFNDsel1(h1), .minFNDsel2(m2), .minFNDsel1(m1),
      .secFNDsel2(s2), .secFNDsel1(s1),
      .hourFND(hseg), .minFND(mseg), .secFND(sseg),
      .hour_out(hour_o[0]), .min_out(min_o[0]), .sec_out(sec_o[0]),
      .time_valid(valid[0]), .frame_done(done[0]), .blank_frame(blank[0]),
      .seg_error(serr[0]), .error_count(ecnt[0]));

   fnd_scan_decoder #(.SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1),
                      .STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut_lo (
      .clk(clk), .reset(reset),
      .hourFNDsel2(~h2), .hourFNDsel1(~h1), .minFNDsel2(~m2), .minFNDsel1(~m1),
      .secFNDsel2(~s2), .secFNDsel1(~s1),
      .hourFND(~hseg), .minFND(~mseg), .secFND(~sseg),
      .hour_out(hour_o[1]), .min_out(min_o[1]), .sec_out(sec_o[1]),
      .time_valid(valid[1]), .frame_done(done[1]), .blank_frame(blank[1]),
      .seg_error(serr[1]), .error_count(ecnt[1]));

   logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   int exp_h, exp_m, exp_s, exp_err;
   bit had_good;
   int good_cyc;

   task automatic check(input string tag, input int idx, input logic [31:0] obs,
                        input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s dut%0d: observed %0d expected %0d", tag, idx, obs, expv);
      end
   endtask

   function automatic int dec(input logic [6:0] p);
      for (int i = 0; i < 10; i++) if (p == seg_tab[i]) return i;
      if (p == 7'b0) return 10;
      return 11;
   endfunction

   function automatic logic [6:0] rand_pat(input int maxd);
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return 7'($urandom);
      if (r == 1) return 7'b0;
      return seg_tab[$urandom_range(0, maxd)];
   endfunction

   function automatic logic [6:0] pat(input int d);
      return seg_tab[d];
   endfunction

   // Drive one select phase for `dwell` cycles; en = {hour,min,sec}.
   // k is the pulse expected at index S+1 of this phase (K_NONE for none).
   task automatic phase(input bit tens, input bit [2:0] en, input logic [6:0] hp,
                        input logic [6:0] mp, input logic [6:0] sp, input int dwell,
                        input kind_e k, input string tag);
      int    cnt  [2];
      int    pos  [2];
      kind_e seen [2];
      cnt  = '{0, 0};
      pos  = '{-1, -1};
      seen = '{K_NONE, K_NONE};
      h2 = en[2] & tens;  h1 = en[2] & ~tens;
      m2 = en[1] & tens;  m1 = en[1] & ~tens;
      s2 = en[0] & tens;  s1 = en[0] & ~tens;
      hseg = hp; mseg = mp; sseg = sp;
      for (int i = 0; i < dwell; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == K_DONE && i == S + 1) begin
            had_good = 1'b1;
            good_cyc = cyc;
         end
         for (int j = 0; j < 2; j++) begin
            check({tag, ":time_valid"}, j, 32'(valid[j]), 32'(had_good && (cyc - good_cyc) < TO));
            if (done[j] | blank[j] | serr[j]) begin
               cnt[j]++;
               pos[j]  = i;
               seen[j] = done[j] ? K_DONE : (blank[j] ? K_BLANK : K_ERR);
               check({tag, ":pulse_onehot"}, j, 32'(done[j]) + 32'(blank[j]) + 32'(serr[j]), 1);
            end
         end
      end
      for (int j = 0; j < 2; j++) begin
         check({tag, ":pulse_count"}, j, cnt[j], (k != K_NONE) ? 1 : 0);
         if (k != K_NONE) begin
            check({tag, ":pulse_kind"}, j, seen[j], k);
            check({tag, ":pulse_latency"}, j, pos[j], S + 1);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int j = 0; j < 2; j++) begin
         check({tag, ":hour"}, j, 32'(hour_o[j]), exp_h);
         check({tag, ":min"},  j, 32'(min_o[j]),  exp_m);
         check({tag, ":sec"},  j, 32'(sec_o[j]),  exp_s);
         check({tag, ":error_count"}, j, 32'(ecnt[j]), exp_err);
      end
   endtask

   // Full multiplexed frame: tens of all channels, then ones of all channels.
   task automatic run_frame(input logic [6:0] ht, input logic [6:0] ho, input logic [6:0] mt,
                            input logic [6:0] mo, input logic [6:0] st, input logic [6:0] so,
                            input int dwell, input string tag);
      logic [6:0] p [6];
      int         d [6];
      bit         inv, blk;
      kind_e      k;
      p   = '{ht, ho, mt, mo, st, so};
      inv = 1'b0;
      blk = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d[i] = dec(p[i]);
         if (d[i] == 11) inv = 1'b1;
         if (d[i] == 10) blk = 1'b1;
      end
      if (inv)                                          k = K_ERR;
      else if (blk)                                     k = K_BLANK;
      else if (d[0] * 10 + d[1] > 23 || d[2] > 5 || d[4] > 5) k = K_ERR;
      else                                              k = K_DONE;
      if (dwell < S) k = K_NONE;
      phase(1'b1, 3'b111, ht, mt, st, dwell, K_NONE, {tag, ":tens"});
      phase(1'b0, 3'b111, ho, mo, so, dwell, k, {tag, ":ones"});
      if (k == K_ERR) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      if (k == K_DONE) begin
         exp_h = d[0] * 10 + d[1];
         exp_m = d[2] * 10 + d[3];
         exp_s = d[4] * 10 + d[5];
      end
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      {h2, h1, m2, m1, s2, s1} = '0;
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         check({tag, ":hour"},        j, 32'(hour_o[j]), 0);
         check({tag, ":min"},         j, 32'(min_o[j]),  0);
         check({tag, ":sec"},         j, 32'(sec_o[j]),  0);
         check({tag, ":time_valid"},  j, 32'(valid[j]),  0);
         check({tag, ":frame_done"},  j, 32'(done[j]),   0);
         check({tag, ":blank_frame"}, j, 32'(blank[j]),  0);
         check({tag, ":seg_error"},   j, 32'(serr[j]),   0);
         check({tag, ":error_count"}, j, 32'(ecnt[j]),   0);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_h = 0; exp_m = 0; exp_s = 0; exp_err = 0;
      had_good = 1'b0;
      good_cyc = 0;
   endtask

   initial begin
      hseg = '0; mseg = '0; sseg = '0;
      do_reset("reset");

      // 12:34:56, normal dwell
      run_frame(pat(1), pat(2), pat(3), pat(4), pat(5), pat(6), DW, "t_123456");

      // 23:59:5? with a non-digit on sec ones
      run_frame(pat(2), pat(3), pat(5), pat(9), pat(5), 7'b1111110, DW, "t_badseg");

      // Blank hour tens, then a normal frame
      run_frame(7'b0, pat(2), pat(3), pat(4), pat(5), pat(6), DW, "t_blank");
      run_frame(pat(0), pat(1), pat(0), pat(2), pat(0), pat(3), DW, "t_after_blank");

      // 27:00:00 out of range
      run_frame(pat(2), pat(7), pat(0), pat(0), pat(0), pat(0), DW, "t_range27");
      // 23:59:59 boundary is legal, 00:60:00 and 00:00:60 are not
      run_frame(pat(2), pat(3), pat(5), pat(9), pat(5), pat(9), DW, "t_235959");
      run_frame(pat(0), pat(0), pat(6), pat(0), pat(0), pat(0), DW, "t_min60");
      run_frame(pat(0), pat(0), pat(0), pat(0), pat(6), pat(0), DW, "t_sec60");

      // Randomized frames
      for (int n = 0; n < 40; n++)
         run_frame(rand_pat(2), rand_pat(9), rand_pat(6), rand_pat(9), rand_pat(6),
                   rand_pat(9), DW, "t_random");

      // Dwell one short of the threshold: nothing captured, time_valid times out
      run_frame(pat(0), pat(9), pat(1), pat(8), pat(2), pat(7), DW, "t_pre_short");
      for (int n = 0; n < 45; n++)
         run_frame(pat(1), pat(1), pat(1), pat(1), pat(1), pat(1), S - 1, "t_short");
      for (int j = 0; j < 2; j++) check("t_short:timed_out", j, 32'(valid[j]), 0);

      // Error counter saturation
      for (int n = 0; n < 300; n++)
         run_frame(pat(2), pat(3), pat(5), pat(9), pat(5), 7'b1111110, DW, "t_sat");
      for (int j = 0; j < 2; j++) check("t_sat:error_count_255", j, 32'(ecnt[j]), 255);

      // Reset after 5 of 6 digits: the partial frame must be discarded
      run_frame(pat(1), pat(5), pat(4), pat(2), pat(3), pat(8), DW, "t_pre_reset");
      phase(1'b1, 3'b111, pat(2), pat(1), pat(4), DW, K_NONE, "t_part:tens");
      phase(1'b0, 3'b110, pat(0), pat(7), pat(0), DW, K_NONE, "t_part:ones");
      do_reset("t_midreset");
      phase(1'b0, 3'b001, pat(0), pat(0), pat(9), DW, K_NONE, "t_lone_digit");
      check_outputs("t_lone_digit");
      run_frame(pat(0), pat(8), pat(1), pat(5), pat(4), pat(2), DW, "t_post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
